ss_seq: RTL and testbench

Save-state sequencer: the initiator side of the mapper save-state port (`ss_act`/`ss_we`/`ss_addr`/`ss_rdat`). On a save command it walks the mapper's state addresses, reads each byte from `ss_rdat` and stores it to a byte-wide state memory. On a load command it first checks the stored mapper index against the live one, then replays the stored bytes into the mapper. It sits between the system controller and the active mapper, and runs on the system clock. Mapper writes are aligned to falling edges of `m2`.

---
 rtl/ss_pkg.sv | 19 +
 rtl/ss_seq_if.sv | 28 ++
 rtl/m2_edge_sync.sv | 33 +++
 rtl/ss_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_ss_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants and state encoding for the save-state sequencer
package ss_pkg;

  localparam int SS_IDX_ADDR  = 127;
  localparam int SS_LAST_ADDR = 15;
  localparam int SS_SLOTS     = SS_LAST_ADDR + 2;

  typedef logic [2:0] ss_state_t;

  localparam ss_state_t ST_IDLE    = 3'd0;
  localparam ss_state_t ST_SV_RD   = 3'd1;
  localparam ss_state_t ST_SV_MEM  = 3'd2;
  localparam ss_state_t ST_LD_IMEM = 3'd3;
  localparam ss_state_t ST_LD_ICMP = 3'd4;
  localparam ss_state_t ST_LD_MEM  = 3'd5;
  localparam ss_state_t ST_LD_WR   = 3'd6;
  localparam ss_state_t ST_FIN     = 3'd7;

endpackage

// File: rtl/ss_seq_if.sv
// rtl/ss_seq_if.sv - mapper save-state port and state-memory request bus
interface ss_seq_if #(
  parameter int MEM_AW = 12
) ();

  logic              ss_act;
  logic              ss_we;
  logic [7:0]        ss_addr;
  logic [7:0]        ss_wdat;
  logic [7:0]        ss_rdat;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdat;
  logic [7:0]        mem_rdat;
  logic              mem_ack;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we, mem_addr, mem_wdat,
    input  ss_rdat, mem_rdat, mem_ack
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat, mem_req, mem_we, mem_addr, mem_wdat,
    output ss_rdat, mem_rdat, mem_ack
  );

endinterface

// File: rtl/m2_edge_sync.sv
// rtl/m2_edge_sync.sv - two-flop m2 synchronizer with falling-edge pulse
module m2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = m2;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/ss_seq.sv
// rtl/ss_seq.sv - save-state sequencer: copies mapper state to memory and replays it back
import ss_pkg::*;

module ss_seq #(
  parameter int MEM_AW    = 12,
  parameter int MEM_BASE  = 0,
  parameter int LAST_ADDR = SS_LAST_ADDR,
  parameter int IDX_ADDR  = SS_IDX_ADDR,
  parameter int SETTLE    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_save,
  input  logic          cmd_load,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          m2,
  ss_seq_if.master      bus
);

  localparam logic [4:0] IDX_SLOT  = 5'(LAST_ADDR + 1);
  localparam logic [4:0] LAST_SLOT = 5'(LAST_ADDR);
  localparam logic [7:0] SETTLE_N  = 8'(SETTLE);

  ss_state_t         state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        sidx_q, sidx_d;
  logic              fail_q, fail_d;
  logic              seen_q, seen_d;
  logic              ss_we_q, ss_we_d;
  logic [7:0]        ss_addr_q, ss_addr_d;
  logic [7:0]        ss_wdat_q, ss_wdat_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdat_q, mem_wdat_d;
  logic              m2_fall;

  m2_edge_sync u_m2_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .m2    (m2),
    .fall  (m2_fall)
  );

  function automatic logic [7:0] map_addr(input logic [4:0] i);
    return (i == IDX_SLOT) ? 8'(IDX_ADDR) : {3'b000, i};
  endfunction

  function automatic logic [MEM_AW-1:0] mem_slot(input logic [4:0] i);
    return MEM_AW'(MEM_BASE) + MEM_AW'(i);
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    sidx_d     = sidx_q;
    fail_d     = fail_q;
    seen_d     = seen_q;
    ss_we_d    = ss_we_q;
    ss_addr_d  = ss_addr_q;
    ss_wdat_d  = ss_wdat_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdat_d = mem_wdat_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_save) begin
          state_d   = ST_SV_RD;
          idx_d     = 5'd0;
          cnt_d     = 8'd0;
          fail_d    = 1'b0;
          ss_addr_d = map_addr(5'd0);
        end else if (cmd_load) begin
          state_d    = ST_LD_IMEM;
          idx_d      = 5'd0;
          fail_d     = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = mem_slot(IDX_SLOT);
        end
      end
      ST_SV_RD: begin
        if (cnt_q == SETTLE_N) begin
          state_d    = ST_SV_MEM;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = mem_slot(idx_q);
          mem_wdat_d = bus.ss_rdat;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SV_MEM: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (idx_q == IDX_SLOT) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_SV_RD;
            idx_d     = idx_q + 5'd1;
            cnt_d     = 8'd0;
            ss_addr_d = map_addr(idx_q + 5'd1);
          end
        end
      end
      ST_LD_IMEM: begin
        if (bus.mem_ack) begin
          state_d   = ST_LD_ICMP;
          mem_req_d = 1'b0;
          sidx_d    = bus.mem_rdat;
          ss_addr_d = 8'(IDX_ADDR);
          cnt_d     = 8'd0;
        end
      end
      ST_LD_ICMP: begin
        if (cnt_q == SETTLE_N) begin
          if (bus.ss_rdat != sidx_q) begin
            state_d = ST_FIN;
            fail_d  = 1'b1;
          end else begin
            state_d    = ST_LD_MEM;
            idx_d      = 5'd0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = mem_slot(5'd0);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LD_MEM: begin
        if (bus.mem_ack) begin
          state_d   = ST_LD_WR;
          mem_req_d = 1'b0;
          ss_wdat_d = bus.mem_rdat;
          ss_addr_d = map_addr(idx_q);
          ss_we_d   = 1'b1;
          seen_d    = 1'b0;
        end
      end
      ST_LD_WR: begin
        // Second detected fall guarantees a whole m2 falling edge landed inside the window.
        if (m2_fall) begin
          if (seen_q) begin
            ss_we_d = 1'b0;
            if (idx_q == LAST_SLOT) begin
              state_d = ST_FIN;
            end else begin
              state_d    = ST_LD_MEM;
              idx_d      = idx_q + 5'd1;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = mem_slot(idx_q + 5'd1);
            end
          end else begin
            seen_d = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      cnt_q      <= 8'd0;
      sidx_q     <= 8'd0;
      fail_q     <= 1'b0;
      seen_q     <= 1'b0;
      ss_we_q    <= 1'b0;
      ss_addr_q  <= 8'd0;
      ss_wdat_q  <= 8'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wdat_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sidx_q     <= sidx_d;
      fail_q     <= fail_d;
      seen_q     <= seen_d;
      ss_we_q    <= ss_we_d;
      ss_addr_q  <= ss_addr_d;
      ss_wdat_q  <= ss_wdat_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdat_q <= mem_wdat_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN) && !fail_q;
  assign err          = (state_q == ST_FIN) && fail_q;
  assign bus.ss_act   = (state_q != ST_IDLE);
  assign bus.ss_we    = ss_we_q;
  assign bus.ss_addr  = ss_addr_q;
  assign bus.ss_wdat  = ss_wdat_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdat = mem_wdat_q;

endmodule

// File: tb/tb_ss_seq.sv
// tb/tb_ss_seq.sv - directed-vector bench for the save-state sequencer
module tb_ss_seq;
  import ss_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_save = 1'b0;
  logic cmd_load = 1'b0;
  logic m2 = 1'b0;
  logic busy, done, err;

  ss_seq_if #(.MEM_AW(12)) bus ();

  ss_seq #(.MEM_AW(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_save (cmd_save),
    .cmd_load (cmd_load),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m2       (m2),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always #57 m2 = ~m2;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mapper model
  logic [7:0] regs [0:15];
  logic [7:0] live_idx = 8'h40;
  assign bus.ss_rdat = (bus.ss_addr == 8'd127) ? live_idx :
                       (bus.ss_addr < 8'd16) ? regs[bus.ss_addr[3:0]] : 8'h00;

  int win_falls = 0;
  int win_miss = 0;
  int n_we = 0;
  always @(negedge m2) begin
    if (bus.ss_act && bus.ss_we) begin
      win_falls++;
      if (bus.ss_addr < 8'd16) regs[bus.ss_addr[3:0]] = bus.ss_wdat;
    end
  end
  always @(posedge bus.ss_we) begin
    n_we++;
    win_falls = 0;
  end
  always @(negedge bus.ss_we) begin
    if (rst_n && win_falls == 0) win_miss++;
  end

  // memory model
  logic [7:0] mem [0:63];
  int lat = 0;
  int wcnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_ack  <= 1'b0;
      bus.mem_rdat <= 8'h00;
      wcnt <= 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
      wcnt <= 0;
    end else if (bus.mem_req) begin
      if (wcnt >= lat) begin
        bus.mem_ack <= 1'b1;
        wcnt <= 0;
        if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdat;
        else bus.mem_rdat <= mem[bus.mem_addr[5:0]];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // pulse counters and request-stability monitor
  int n_done = 0;
  int n_err = 0;
  int stab_bad = 0;
  logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [11:0] p_addr = '0;
  logic [7:0] p_wdat = '0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (p_req && !p_ack) begin
      if (!bus.mem_req || bus.mem_addr !== p_addr || bus.mem_we !== p_we ||
          (p_we && bus.mem_wdat !== p_wdat)) stab_bad++;
    end
    if (p_ack && bus.mem_req) stab_bad++;
    p_req  = bus.mem_req;
    p_ack  = bus.mem_ack;
    p_we   = bus.mem_we;
    p_addr = bus.mem_addr;
    p_wdat = bus.mem_wdat;
  end

  task automatic clr_counts();
    n_done = 0;
    n_err = 0;
    n_we = 0;
    win_miss = 0;
  endtask

  task automatic pulse_cmd(input logic s, input logic l);
    cmd_save = s;
    cmd_load = l;
    @(negedge clk);
    cmd_save = 1'b0;
    cmd_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic s, input logic l, output int cyc);
    clr_counts();
    pulse_cmd(s, l);
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    wait_idle(tag, cyc);
  endtask

  task automatic set_mapper_save_pattern();
    for (int k = 0; k < 16; k++) regs[k] = 8'(8'h40 + k);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) mem[k] = 8'h00;
  endtask

  task automatic check_saved(input string tag);
    for (int k = 0; k < SS_SLOTS; k++)
      chk($sformatf("%s_mem%0d", tag, k), {24'd0, mem[k]},
          (k == SS_SLOTS - 1) ? 32'h40 : 32'(8'h40 + k));
  endtask

  task automatic set_load_mem(input logic [7:0] stored_idx);
    for (int k = 0; k < 16; k++) mem[k] = 8'(8'hA0 + k);
    mem[16] = stored_idx;
  endtask

  int cyc;
  int guard;

  initial begin
    clear_mem();
    for (int k = 0; k < 16; k++) regs[k] = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_ss_act", {31'd0, bus.ss_act}, 0);
    chk("rst_ss_we", {31'd0, bus.ss_we}, 0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 0);
    chk("rst_ss_addr", {24'd0, bus.ss_addr}, 0);
    chk("rst_ss_wdat", {24'd0, bus.ss_wdat}, 0);
    chk("rst_mem_addr", {20'd0, bus.mem_addr}, 0);
    chk("rst_mem_wdat", {24'd0, bus.mem_wdat}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // save, single-cycle ack: 17 slots x (4 settle + 2 mem) + 1 FIN
    set_mapper_save_pattern();
    clear_mem();
    lat = 0;
    do_op("save", 1'b1, 1'b0, cyc);
    chk("save_cycles", cyc, 103);
    chk("save_done", n_done, 1);
    chk("save_err", n_err, 0);
    check_saved("save");

    // save with 20-cycle ack stall: 17 x (4 + 22) + 1
    clear_mem();
    lat = 20;
    stab_bad = 0;
    do_op("stall", 1'b1, 1'b0, cyc);
    chk("stall_cycles", cyc, 443);
    chk("stall_done", n_done, 1);
    chk("stall_stable", stab_bad, 0);
    check_saved("stall");
    lat = 0;

    // load with matching index
    set_load_mem(8'h40);
    for (int k = 0; k < 16; k++) regs[k] = 8'h00;
    do_op("ldok", 1'b0, 1'b1, cyc);
    for (int k = 0; k < 16; k++)
      chk($sformatf("ldok_reg%0d", k), {24'd0, regs[k]}, 32'(8'hA0 + k));
    chk("ldok_we_count", n_we, 16);
    chk("ldok_window_m2", win_miss, 0);
    chk("ldok_done", n_done, 1);
    chk("ldok_err", n_err, 0);

    // load with index mismatch
    set_load_mem(8'h41);
    for (int k = 0; k < 16; k++) regs[k] = 8'h11;
    do_op("ldbad", 1'b0, 1'b1, cyc);
    chk("ldbad_we_count", n_we, 0);
    chk("ldbad_err", n_err, 1);
    chk("ldbad_done", n_done, 0);
    chk("ldbad_ss_act", {31'd0, bus.ss_act}, 0);
    chk("ldbad_reg5", {24'd0, regs[5]}, 32'h11);

    // simultaneous commands, then load while busy
    set_mapper_save_pattern();
    clear_mem();
    clr_counts();
    pulse_cmd(1'b1, 1'b1);
    repeat (10) @(negedge clk);
    pulse_cmd(1'b0, 1'b1);
    wait_idle("dual", cyc);
    repeat (5) @(negedge clk);
    chk("dual_idle", {31'd0, busy}, 0);
    chk("dual_done", n_done, 1);
    chk("dual_we_count", n_we, 0);
    check_saved("dual");

    // reset during LD_WR
    set_load_mem(8'h40);
    for (int k = 0; k < 16; k++) regs[k] = 8'h00;
    clr_counts();
    pulse_cmd(1'b0, 1'b1);
    guard = 0;
    while (!bus.ss_we && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("rstwr_reached", {31'd0, bus.ss_we}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr_busy", {31'd0, busy}, 0);
    chk("rstwr_ss_act", {31'd0, bus.ss_act}, 0);
    chk("rstwr_ss_we", {31'd0, bus.ss_we}, 0);
    chk("rstwr_ss_addr", {24'd0, bus.ss_addr}, 0);
    chk("rstwr_ss_wdat", {24'd0, bus.ss_wdat}, 0);
    chk("rstwr_mem_req", {31'd0, bus.mem_req}, 0);
    chk("rstwr_mem_addr", {20'd0, bus.mem_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstwr_no_done", n_done, 0);
    chk("rstwr_no_err", n_err, 0);

    set_mapper_save_pattern();
    clear_mem();
    do_op("postrst", 1'b1, 1'b0, cyc);
    chk("postrst_cycles", cyc, 103);
    chk("postrst_done", n_done, 1);
    check_saved("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
